serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl.sv | 106 ++++++++++
 tb/tb_serial_add_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell shared across all WIDTH bit positions, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
`timescale 1ns/1ps
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] a_sr_reg;
    logic [WIDTH-1:0] b_sr_reg;
    logic [WIDTH-1:0] sum_sr_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_reg;
`endif

    // The single shared full-adder cell.
    logic fa_sum;
    logic fa_cout;
    logic last_bit;

    assign fa_sum   = a_sr_reg[0] ^ b_sr_reg[0] ^ carry_reg;
    assign fa_cout  = (a_sr_reg[0] & b_sr_reg[0]) | (carry_reg & (a_sr_reg[0] ^ b_sr_reg[0]));
    assign last_bit = (cnt_reg == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            a_sr_reg   <= '0;
            b_sr_reg   <= '0;
            sum_sr_reg <= '0;
            carry_reg  <= 1'b0;
            cnt_reg    <= '0;
            sum_reg    <= '0;
            cout_reg   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_reg    <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_sr_reg   <= a;
                        b_sr_reg   <= b;
                        carry_reg  <= cin;
                        cnt_reg    <= '0;
                        sum_sr_reg <= '0;
                        state_reg  <= ST_RUN;
                    end else begin
                        state_reg  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_sr_reg   <= {1'b0, a_sr_reg[WIDTH-1:1]};
                    b_sr_reg   <= {1'b0, b_sr_reg[WIDTH-1:1]};
                    sum_sr_reg <= {fa_sum, sum_sr_reg[WIDTH-1:1]};
                    carry_reg  <= fa_cout;
                    cnt_reg    <= cnt_reg + CW'(1);
                    // Published results only move on the final bit so they stay stable during the next run.
                    if (last_bit) begin
                        sum_reg   <= {fa_sum, sum_sr_reg[WIDTH-1:1]};
                        cout_reg  <= fa_cout;
`ifdef SERIAL_ADD_OVF_EN
                        ovf_reg   <= carry_reg ^ fa_cout;
`endif
                        state_reg <= ST_DONE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state_reg == ST_RUN);
    assign done = (state_reg == ST_DONE);
    assign sum  = sum_reg;
    assign cout = cout_reg;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf  = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at WIDTH=8; covers ovf when SERIAL_ADD_OVF_EN is defined.
`timescale 1ns/1ps
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
`ifdef SERIAL_ADD_OVF_EN
    logic       ovf;
`endif

    int vectors = 0;
    int miscompares = 0;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge, then wait (bounded) for done; reports edges from accept to done.
    task automatic launch(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                          output int lat, output int busy_cnt, output bit overlap);
        a = va; b = vb; cin = vc; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0; busy_cnt = 0; overlap = 1'b0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            tick();
            lat++;
        end
        if (busy && done) overlap = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        tick(); tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", done); end
        vectors++; if (sum !== 8'h00) begin miscompares++; $display("FAIL reset_sum got=%h exp=00", sum); end
        vectors++; if (cout !== 1'b0) begin miscompares++; $display("FAIL reset_cout got=%b exp=0", cout); end
`ifdef SERIAL_ADD_OVF_EN
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`endif
        rst_n = 1'b1;
        tick();
        $display("test_reset: outputs after reset checked");
    endtask

    task automatic test_basic();
        int lat, bc; bit ov;
        launch(8'h0F, 8'h01, 1'b0, lat, bc, ov);
        vectors++; if (lat !== 8) begin miscompares++; $display("FAIL basic_latency got=%0d exp=8", lat); end
        vectors++; if (bc !== 8) begin miscompares++; $display("FAIL basic_busy_cycles got=%0d exp=8", bc); end
        vectors++; if (ov) begin miscompares++; $display("FAIL basic_overlap got=1 exp=0"); end
        vectors++; if (sum !== 8'h10) begin miscompares++; $display("FAIL basic_sum got=%h exp=10", sum); end
        vectors++; if (cout !== 1'b0) begin miscompares++; $display("FAIL basic_cout got=%b exp=0", cout); end
        tick();
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done_width got=%b exp=0", done); end
        vectors++; if (sum !== 8'h10) begin miscompares++; $display("FAIL basic_sum_hold got=%h exp=10", sum); end
        $display("test_basic: 0F+01+0 -> sum=%h cout=%b lat=%0d", sum, cout, lat);
    endtask

    task automatic test_carry();
        int lat, bc; bit ov;
        launch(8'hFF, 8'h01, 1'b0, lat, bc, ov);
        vectors++; if (sum !== 8'h00) begin miscompares++; $display("FAIL carry_sum got=%h exp=00", sum); end
        vectors++; if (cout !== 1'b1) begin miscompares++; $display("FAIL carry_cout got=%b exp=1", cout); end
        $display("test_carry: FF+01+0 -> sum=%h cout=%b", sum, cout);
        tick();
        launch(8'h00, 8'h00, 1'b1, lat, bc, ov);
        vectors++; if (sum !== 8'h01) begin miscompares++; $display("FAIL cin_sum got=%h exp=01", sum); end
        vectors++; if (cout !== 1'b0) begin miscompares++; $display("FAIL cin_cout got=%b exp=0", cout); end
        vectors++; if (lat !== 8) begin miscompares++; $display("FAIL cin_latency got=%0d exp=8", lat); end
        $display("test_carry: 00+00+1 -> sum=%h cout=%b", sum, cout);
        tick();
    endtask

    task automatic test_ignore_start();
        int n; int dones; logic [7:0] mid_sum;
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; n = 0;
        tick(); tick(); n = 2;
        mid_sum = sum;
        a = 8'h55; start = 1'b1;
        tick(); n++;
        start = 1'b0; a = 8'h00;
        while (!done && n < 20) begin tick(); n++; end
        vectors++; if (mid_sum !== 8'h01) begin miscompares++; $display("FAIL ignore_sum_stable got=%h exp=01", mid_sum); end
        vectors++; if (n !== 8) begin miscompares++; $display("FAIL ignore_latency got=%0d exp=8", n); end
        vectors++; if (sum !== 8'h46) begin miscompares++; $display("FAIL ignore_sum got=%h exp=46", sum); end
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) dones++;
        end
        vectors++; if (dones !== 0) begin miscompares++; $display("FAIL ignore_extra_done got=%0d exp=0", dones); end
        $display("test_ignore_start: 12+34 with start during run -> sum=%h extra_dones=%0d", sum, dones);
    endtask

    task automatic test_back_to_back();
        int t[3]; int k; bit ov; bit bad_res; int n;
        k = 0; ov = 0; bad_res = 0;
        a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
        for (int cyc = 1; cyc <= 40 && k < 3; cyc++) begin
            tick();
            if (busy && done) ov = 1'b1;
            if (done) begin
                t[k] = cyc; k++;
                if (sum !== 8'h00 || cout !== 1'b1) bad_res = 1'b1;
            end
        end
        start = 1'b0;
        vectors++; if (k !== 3) begin miscompares++; $display("FAIL b2b_done_count got=%0d exp=3", k); end
        vectors++; if (t[0] !== 9) begin miscompares++; $display("FAIL b2b_first_done got=%0d exp=9", t[0]); end
        vectors++; if (t[1] - t[0] !== 9) begin miscompares++; $display("FAIL b2b_period1 got=%0d exp=9", t[1] - t[0]); end
        vectors++; if (t[2] - t[1] !== 9) begin miscompares++; $display("FAIL b2b_period2 got=%0d exp=9", t[2] - t[1]); end
        vectors++; if (bad_res) begin miscompares++; $display("FAIL b2b_result got=%h/%b exp=00/1", sum, cout); end
        vectors++; if (ov) begin miscompares++; $display("FAIL b2b_overlap got=1 exp=0"); end
        n = 0;
        while ((busy || done) && n < 20) begin tick(); n++; end
        $display("test_back_to_back: dones at %0d,%0d,%0d sum=%h cout=%b", t[0], t[1], t[2], sum, cout);
    endtask

    task automatic test_reset_midrun();
        int dones; int lat, bc; bit ov;
        a = 8'hAA; b = 8'h11; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%b exp=0", busy); end
        vectors++; if (sum !== 8'h00) begin miscompares++; $display("FAIL rst_sum got=%h exp=00", sum); end
        vectors++; if (cout !== 1'b0) begin miscompares++; $display("FAIL rst_cout got=%b exp=0", cout); end
        tick();
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) dones++;
        end
        vectors++; if (dones !== 0) begin miscompares++; $display("FAIL rst_no_done got=%0d exp=0", dones); end
        launch(8'h3C, 8'h0C, 1'b0, lat, bc, ov);
        vectors++; if (sum !== 8'h48) begin miscompares++; $display("FAIL rst_next_sum got=%h exp=48", sum); end
        vectors++; if (lat !== 8) begin miscompares++; $display("FAIL rst_next_latency got=%0d exp=8", lat); end
        $display("test_reset_midrun: post-reset 3C+0C -> sum=%h cout=%b", sum, cout);
        tick();
    endtask

`ifdef SERIAL_ADD_OVF_EN
    task automatic test_ovf();
        int lat, bc; bit ov;
        launch(8'h7F, 8'h01, 1'b0, lat, bc, ov);
        vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_pos got=%b exp=1", ovf); end
        vectors++; if (sum !== 8'h80) begin miscompares++; $display("FAIL ovf_pos_sum got=%h exp=80", sum); end
        $display("test_ovf: 7F+01 -> sum=%h ovf=%b", sum, ovf);
        tick();
        launch(8'hFF, 8'h01, 1'b0, lat, bc, ov);
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_neg got=%b exp=0", ovf); end
        vectors++; if (cout !== 1'b1) begin miscompares++; $display("FAIL ovf_neg_cout got=%b exp=1", cout); end
        $display("test_ovf: FF+01 -> sum=%h cout=%b ovf=%b", sum, cout, ovf);
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_ignore_start();
        test_back_to_back();
        test_reset_midrun();
`ifdef SERIAL_ADD_OVF_EN
        test_ovf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
